// File: rtl/calc_pkg.sv
// Shared definitions for the calculator entry core:
// state codes, operator codes and key decoding.
package calc_pkg;

    typedef enum logic [2:0] {
        S_NUM1   = 3'd0,
        S_OP     = 3'd1,
        S_NUM2   = 3'd2,
        S_CALC   = 3'd3,
        S_RESULT = 3'd4,
        S_ERR    = 3'd5
    } state_t;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;
    localparam logic [1:0] OP_DIV = 2'd3;

    localparam logic [3:0] BCD_ERR_NIBBLE = 4'hE;

    typedef struct packed {
        logic clr;
        logic eq;
        logic op;
        logic num;
    } key_t;

    // One-hot key class with clr > eq > op > num priority; illegal digits dropped.
    function automatic key_t decode_key(
        input logic       v,
        input logic       n,
        input logic       o,
        input logic       e,
        input logic       c,
        input logic [3:0] d
    );
        key_t k;
        k.clr = v & c;
        k.eq  = v & ~c & e;
        k.op  = v & ~c & ~e & o;
        k.num = v & ~c & ~e & ~o & n & (d <= 4'd9);
        return k;
    endfunction

endpackage

// File: rtl/bcd_entry_reg.sv
// Shift-in BCD operand register with a saturating digit
// counter plus clear, load and start-with-digit controls.
module bcd_entry_reg #(
    parameter int N_DIGITS = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_clr,
    input  logic                  i_load,
    input  logic [4*N_DIGITS-1:0] i_load_val,
    input  logic                  i_start,
    input  logic                  i_shift,
    input  logic [3:0]            i_digit,
    output logic [4*N_DIGITS-1:0] o_val,
    output logic [4*N_DIGITS-1:0] o_next
);

    localparam int W  = 4 * N_DIGITS;
    localparam int CW = $clog2(N_DIGITS + 1);
    localparam logic [CW-1:0] FULL = CW'(N_DIGITS);

    logic [W-1:0]  r_val;
    logic [W-1:0]  w_val;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt;
    logic          w_lead_zero;

    // A zero typed into an empty register changes nothing.
    assign w_lead_zero = (r_cnt == '0) && (i_digit == 4'd0);

    always_comb begin
        w_val = r_val;
        w_cnt = r_cnt;
        if (i_clr) begin
            w_val = '0;
            w_cnt = '0;
        end else if (i_load) begin
            w_val = i_load_val;
            w_cnt = FULL;
        end else if (i_start) begin
            w_val = W'(i_digit);
            w_cnt = (i_digit != 4'd0) ? CW'(1) : '0;
        end else if (i_shift && (r_cnt != FULL) && !w_lead_zero) begin
            w_val = W'({r_val, i_digit});
            w_cnt = r_cnt + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_val <= '0;
            r_cnt <= '0;
        end else begin
            r_val <= w_val;
            r_cnt <= w_cnt;
        end
    end

    assign o_val  = r_val;
    assign o_next = w_val;

endmodule

// File: rtl/calc_entry_fsm.sv
// Calculator control core: keypad events to BCD operands,
// operator, ALU request/ack handshake and display selection.
module calc_entry_fsm
    import calc_pkg::*;
#(
    parameter int N_DIGITS    = 4,
    parameter int OP_W        = 2,
    parameter int ALU_TIMEOUT = 255
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_key_valid,
    input  logic                  i_is_num,
    input  logic                  i_is_op,
    input  logic                  i_is_eq,
    input  logic                  i_is_clr,
    input  logic [3:0]            i_num_val,
    input  logic [OP_W-1:0]       i_op_val,
    output logic                  o_alu_start,
    input  logic                  i_alu_done,
    input  logic                  i_alu_err,
    input  logic [4*N_DIGITS-1:0] i_alu_result,
    output logic [4*N_DIGITS-1:0] o_num1_bcd,
    output logic [4*N_DIGITS-1:0] o_num2_bcd,
    output logic [OP_W-1:0]       o_operation,
    output logic [4*N_DIGITS-1:0] o_result_bcd,
    output logic [4*N_DIGITS-1:0] o_show_bcd,
    output logic                  o_disp_update,
    output logic [2:0]            o_curr_state
);

    localparam int W  = 4 * N_DIGITS;
    localparam int TW = $clog2(ALU_TIMEOUT + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(ALU_TIMEOUT - 1);
    localparam logic [W-1:0]  ERR_SHOW = {N_DIGITS{BCD_ERR_NIBBLE}};

    state_t          r_state;
    state_t          w_next;
    key_t            w_key;
    logic [TW-1:0]   r_tmo;
    logic            w_tmo_hit;

    logic [OP_W-1:0] r_op;
    logic [W-1:0]    r_res;
    logic [W-1:0]    r_show;
    logic            r_disp;
    logic            r_start;

    logic            w_n1_clr;
    logic            w_n1_load;
    logic            w_n1_start;
    logic            w_n1_shift;
    logic            w_n2_clr;
    logic            w_n2_start;
    logic            w_n2_shift;
    logic            w_op_ld;
    logic            w_op_clr;
    logic            w_res_ld;
    logic            w_res_clr;
    logic            w_start;
    logic            w_accept;

    logic [W-1:0]    w_n1_val;
    logic [W-1:0]    w_n1_next;
    logic [W-1:0]    w_n2_val;
    logic [W-1:0]    w_n2_next;
    logic [W-1:0]    w_res_next;
    logic [W-1:0]    w_show;

    assign w_key = decode_key(i_key_valid, i_is_num, i_is_op,
                              i_is_eq, i_is_clr, i_num_val);

    assign w_tmo_hit = (r_tmo == TO_LAST);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_NUM1;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (w_key.clr) begin
            w_next = S_NUM1;
        end else begin
            case (r_state)
                S_NUM1:   if (w_key.op) w_next = S_OP;
                S_OP:     if (w_key.num) w_next = S_NUM2;
                S_NUM2:   if (w_key.eq) w_next = S_CALC;
                S_CALC: begin
                    if (i_alu_done) begin
                        w_next = i_alu_err ? S_ERR : S_RESULT;
                    end else if (w_tmo_hit) begin
                        w_next = S_ERR;
                    end
                end
                S_RESULT: begin
                    if (w_key.op) begin
                        w_next = S_OP;
                    end else if (w_key.num) begin
                        w_next = S_NUM1;
                    end
                end
                S_ERR:    w_next = S_ERR;
                default:  w_next = S_NUM1;
            endcase
        end
    end

    always_comb begin
        w_n1_clr   = 1'b0;
        w_n1_load  = 1'b0;
        w_n1_start = 1'b0;
        w_n1_shift = 1'b0;
        w_n2_clr   = 1'b0;
        w_n2_start = 1'b0;
        w_n2_shift = 1'b0;
        w_op_ld    = 1'b0;
        w_op_clr   = 1'b0;
        w_res_ld   = 1'b0;
        w_res_clr  = 1'b0;
        w_start    = 1'b0;
        w_accept   = 1'b0;
        if (w_key.clr) begin
            w_n1_clr  = 1'b1;
            w_n2_clr  = 1'b1;
            w_op_clr  = 1'b1;
            w_res_clr = 1'b1;
            w_accept  = 1'b1;
        end else begin
            case (r_state)
                S_NUM1: begin
                    w_op_ld    = w_key.op;
                    w_n1_shift = w_key.num;
                    w_accept   = w_key.op | w_key.num;
                end
                S_OP: begin
                    w_op_ld    = w_key.op;
                    w_n2_start = w_key.num;
                    w_accept   = w_key.op | w_key.num;
                end
                S_NUM2: begin
                    w_start    = w_key.eq;
                    w_n2_shift = w_key.num;
                    w_accept   = w_key.eq | w_key.num;
                end
                S_CALC: begin
                    w_res_ld = i_alu_done;
                end
                S_RESULT: begin
                    // Chaining reuses the result as the new first operand.
                    w_n1_load  = w_key.op;
                    w_op_ld    = w_key.op;
                    w_n1_start = w_key.num;
                    w_res_clr  = w_key.num;
                    w_n2_clr   = w_key.op | w_key.num;
                    w_accept   = w_key.op | w_key.num;
                end
                default: begin
                    w_accept = 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        w_res_next = r_res;
        if (w_res_clr) begin
            w_res_next = '0;
        end else if (w_res_ld) begin
            w_res_next = i_alu_result;
        end
    end

    always_comb begin
        w_show = '0;
        case (w_next)
            S_NUM1, S_OP:   w_show = w_n1_next;
            S_NUM2, S_CALC: w_show = w_n2_next;
            S_RESULT:       w_show = w_res_next;
            S_ERR:          w_show = ERR_SHOW;
            default:        w_show = '0;
        endcase
    end

    bcd_entry_reg #(.N_DIGITS(N_DIGITS)) u_num1 (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_clr      (w_n1_clr),
        .i_load     (w_n1_load),
        .i_load_val (r_res),
        .i_start    (w_n1_start),
        .i_shift    (w_n1_shift),
        .i_digit    (i_num_val),
        .o_val      (w_n1_val),
        .o_next     (w_n1_next)
    );

    bcd_entry_reg #(.N_DIGITS(N_DIGITS)) u_num2 (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_clr      (w_n2_clr),
        .i_load     (1'b0),
        .i_load_val ('0),
        .i_start    (w_n2_start),
        .i_shift    (w_n2_shift),
        .i_digit    (i_num_val),
        .o_val      (w_n2_val),
        .o_next     (w_n2_next)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_op    <= '0;
            r_res   <= '0;
            r_show  <= '0;
            r_disp  <= 1'b0;
            r_start <= 1'b0;
            r_tmo   <= '0;
        end else begin
            if (w_op_clr) begin
                r_op <= '0;
            end else if (w_op_ld) begin
                r_op <= i_op_val;
            end
            r_res   <= w_res_next;
            r_show  <= w_show;
            r_disp  <= w_accept | (w_next != r_state);
            r_start <= w_start;
            // Counts cycles spent waiting; zero on entry to S_CALC.
            if ((r_state == S_CALC) && (w_next == S_CALC)) begin
                r_tmo <= r_tmo + 1'b1;
            end else begin
                r_tmo <= '0;
            end
        end
    end

    assign o_alu_start   = r_start;
    assign o_num1_bcd    = w_n1_val;
    assign o_num2_bcd    = w_n2_val;
    assign o_operation   = r_op;
    assign o_result_bcd  = r_res;
    assign o_show_bcd    = r_show;
    assign o_disp_update = r_disp;
    assign o_curr_state  = r_state;

endmodule

// File: tb/tb_calc_entry_fsm.sv
// Self-checking bench for calc_entry_fsm: directed scenarios
// plus randomized keys against a decimal reference model.
module tb_calc_entry_fsm;

    localparam int ND  = 4;
    localparam int W   = 16;
    localparam int TMO = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          key_valid, is_num, is_op, is_eq, is_clr;
    logic [3:0]    num_val;
    logic [1:0]    op_val;
    logic          alu_start;
    logic          alu_done, alu_err;
    logic [W-1:0]  alu_result;
    logic [W-1:0]  num1_bcd, num2_bcd, result_bcd, show_bcd;
    logic [1:0]    operation;
    logic          disp_update;
    logic [2:0]    curr_state;

    int checks = 0;
    int errors = 0;
    int g_starts = 0;

    // Reference model: operands kept as decimal integers plus digit counts.
    int         m_st, m_n1, m_c1, m_n2, m_c2, m_tmo;
    logic [1:0] m_op;
    logic [W-1:0] m_res;
    bit         m_start, m_disp;

    calc_entry_fsm #(.N_DIGITS(ND), .OP_W(2), .ALU_TIMEOUT(TMO)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_key_valid   (key_valid),
        .i_is_num      (is_num),
        .i_is_op       (is_op),
        .i_is_eq       (is_eq),
        .i_is_clr      (is_clr),
        .i_num_val     (num_val),
        .i_op_val      (op_val),
        .o_alu_start   (alu_start),
        .i_alu_done    (alu_done),
        .i_alu_err     (alu_err),
        .i_alu_result  (alu_result),
        .o_num1_bcd    (num1_bcd),
        .o_num2_bcd    (num2_bcd),
        .o_operation   (operation),
        .o_result_bcd  (result_bcd),
        .o_show_bcd    (show_bcd),
        .o_disp_update (disp_update),
        .o_curr_state  (curr_state)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] to_bcd(input int v);
        logic [W-1:0] r;
        int x;
        r = '0;
        x = v;
        for (int i = 0; i < ND; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic int from_bcd(input logic [W-1:0] b);
        int v;
        v = 0;
        for (int i = ND - 1; i >= 0; i--) v = v * 10 + int'(b[4*i +: 4]);
        return v;
    endfunction

    function automatic void enter(inout int v, inout int c, input int d);
        if (c < ND && !(c == 0 && d == 0)) begin
            v = v * 10 + d;
            c = c + 1;
        end
    endfunction

    function automatic void model_clear();
        m_n1 = 0; m_c1 = 0; m_n2 = 0; m_c2 = 0;
        m_res = '0; m_op = '0; m_st = 0; m_tmo = 0;
    endfunction

    function automatic logic [W-1:0] exp_show();
        case (m_st)
            0, 1:    return to_bcd(m_n1);
            2, 3:    return to_bcd(m_n2);
            4:       return m_res;
            default: return {ND{4'hE}};
        endcase
    endfunction

    function automatic logic [70:0] exp_all();
        return {m_start, to_bcd(m_n1), to_bcd(m_n2), m_op, m_res,
                exp_show(), m_disp, 3'(m_st)};
    endfunction

    function automatic void model_step(
        input bit kv, input bit n, input bit o, input bit e, input bit c,
        input logic [3:0] nv, input logic [1:0] ov,
        input bit dn, input bit er, input logic [W-1:0] res
    );
        int prev;
        bit acc, k_clr, k_eq, k_op, k_num;
        prev = m_st;
        acc = 0;
        k_clr = kv && c;
        k_eq = kv && !c && e;
        k_op = kv && !c && !e && o;
        k_num = kv && !c && !e && !o && n && (nv <= 9);
        m_start = 0;
        if (k_clr) begin
            model_clear();
            acc = 1;
        end else begin
            case (m_st)
                0: if (k_op) begin m_op = ov; m_st = 1; acc = 1; end
                   else if (k_num) begin enter(m_n1, m_c1, int'(nv)); acc = 1; end
                1: if (k_op) begin m_op = ov; acc = 1; end
                   else if (k_num) begin
                       m_n2 = int'(nv); m_c2 = (nv != 0) ? 1 : 0; m_st = 2; acc = 1;
                   end
                2: if (k_eq) begin m_start = 1; m_st = 3; m_tmo = 0; acc = 1; end
                   else if (k_num) begin enter(m_n2, m_c2, int'(nv)); acc = 1; end
                3: if (dn) begin m_res = res; m_st = er ? 5 : 4; end
                   else begin
                       m_tmo++;
                       if (m_tmo == TMO) m_st = 5;
                   end
                4: if (k_op) begin
                       m_n1 = from_bcd(m_res); m_c1 = ND; m_n2 = 0; m_c2 = 0;
                       m_op = ov; m_st = 1; acc = 1;
                   end else if (k_num) begin
                       m_n1 = int'(nv); m_c1 = (nv != 0) ? 1 : 0;
                       m_n2 = 0; m_c2 = 0; m_res = '0; m_st = 0; acc = 1;
                   end
                default: ;
            endcase
        end
        m_disp = acc || (m_st != prev);
    endfunction

    task automatic drive(
        input bit kv, input bit n, input bit o, input bit e, input bit c,
        input logic [3:0] nv, input logic [1:0] ov,
        input bit dn, input bit er, input logic [W-1:0] res
    );
        key_valid = kv; is_num = n; is_op = o; is_eq = e; is_clr = c;
        num_val = nv; op_val = ov;
        alu_done = dn; alu_err = er; alu_result = res;
        model_step(kv, n, o, e, c, nv, ov, dn, er, res);
        @(posedge clk);
        #1;
        key_valid = 0; is_num = 0; is_op = 0; is_eq = 0; is_clr = 0;
        alu_done = 0; alu_err = 0;
        if (alu_start === 1'b1) g_starts++;
    endtask

    task automatic press_num(input int d);
        drive(1, 1, 0, 0, 0, 4'(d), 2'd0, 0, 0, '0);
    endtask
    task automatic press_op(input logic [1:0] o);
        drive(1, 0, 1, 0, 0, 4'd0, o, 0, 0, '0);
    endtask
    task automatic press_eq();
        drive(1, 0, 0, 1, 0, 4'd0, 2'd0, 0, 0, '0);
    endtask
    task automatic press_clr();
        drive(1, 0, 0, 0, 1, 4'd0, 2'd0, 0, 0, '0);
    endtask
    task automatic idle();
        drive(0, 0, 0, 0, 0, 4'd0, 2'd0, 0, 0, '0);
    endtask
    task automatic alu(input bit er, input logic [W-1:0] res);
        drive(0, 0, 0, 0, 0, 4'd0, 2'd0, 1, er, res);
    endtask

    task automatic do_reset();
        rst = 1;
        model_clear();
        m_start = 0;
        m_disp = 0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({alu_start, num1_bcd, num2_bcd, operation, result_bcd, show_bcd,
             disp_update, curr_state} !== 71'd0) begin
            errors++;
            $display("FAIL reset_outputs got %h exp 0", {alu_start, num1_bcd,
                     num2_bcd, operation, result_bcd, show_bcd, disp_update, curr_state});
        end
    endtask

    task automatic test_basic();
        int s0;
        do_reset();
        s0 = g_starts;
        press_num(1); press_num(2); press_op(2'd0);
        press_num(3); press_num(4); press_eq();
        checks++;
        if (alu_start !== 1'b1 || curr_state !== 3'd3) begin
            errors++;
            $display("FAIL basic_start got start=%b st=%0d exp 1/3", alu_start, curr_state);
        end
        idle(); idle(); alu(0, 16'h0046);
        checks++;
        if (num1_bcd !== 16'h0012 || num2_bcd !== 16'h0034) begin
            errors++;
            $display("FAIL basic_operands got %h %h exp 0012 0034", num1_bcd, num2_bcd);
        end
        checks++;
        if (curr_state !== 3'd4 || show_bcd !== 16'h0046 || disp_update !== 1'b1) begin
            errors++;
            $display("FAIL basic_result got st=%0d show=%h disp=%b exp 4 0046 1",
                     curr_state, show_bcd, disp_update);
        end
        checks++;
        if (g_starts - s0 != 1) begin
            errors++;
            $display("FAIL basic_pulses got %0d exp 1", g_starts - s0);
        end
    endtask

    task automatic test_chain();
        press_op(2'd1); press_num(6); press_eq();
        checks++;
        if (num1_bcd !== 16'h0046 || num2_bcd !== 16'h0006 || operation !== 2'd1) begin
            errors++;
            $display("FAIL chain_operands got %h %h op=%0d exp 0046 0006 1",
                     num1_bcd, num2_bcd, operation);
        end
        checks++;
        if (alu_start !== 1'b1 || show_bcd !== 16'h0006) begin
            errors++;
            $display("FAIL chain_start got start=%b show=%h exp 1 0006", alu_start, show_bcd);
        end
        alu(0, 16'h0040);
        checks++;
        if (show_bcd !== 16'h0040 || result_bcd !== 16'h0040 || alu_start !== 1'b0) begin
            errors++;
            $display("FAIL chain_result got show=%h res=%h start=%b exp 0040 0040 0",
                     show_bcd, result_bcd, alu_start);
        end
    endtask

    task automatic test_digits();
        press_clr();
        for (int d = 1; d <= 5; d++) press_num(d);
        checks++;
        if (num1_bcd !== 16'h1234 || show_bcd !== 16'h1234) begin
            errors++;
            $display("FAIL digits_saturate got %h show=%h exp 1234", num1_bcd, show_bcd);
        end
        press_clr(); press_num(0); press_num(0); press_num(7);
        checks++;
        if (num1_bcd !== 16'h0007 || curr_state !== 3'd0) begin
            errors++;
            $display("FAIL digits_leading_zero got %h st=%0d exp 0007 0", num1_bcd, curr_state);
        end
        press_eq();
        checks++;
        if (curr_state !== 3'd0 || disp_update !== 1'b0) begin
            errors++;
            $display("FAIL digits_eq_ignored got st=%0d disp=%b exp 0 0", curr_state, disp_update);
        end
    endtask

    task automatic test_err();
        press_clr(); press_num(5); press_op(2'd3); press_num(0); press_eq();
        alu(1, 16'h0000);
        checks++;
        if (curr_state !== 3'd5 || show_bcd !== 16'hEEEE) begin
            errors++;
            $display("FAIL err_enter got st=%0d show=%h exp 5 EEEE", curr_state, show_bcd);
        end
        press_num(9); press_eq();
        checks++;
        if (curr_state !== 3'd5 || show_bcd !== 16'hEEEE || disp_update !== 1'b0) begin
            errors++;
            $display("FAIL err_sticky got st=%0d show=%h disp=%b exp 5 EEEE 0",
                     curr_state, show_bcd, disp_update);
        end
        press_clr();
        checks++;
        if ({num1_bcd, num2_bcd, operation, result_bcd, show_bcd, curr_state} !== 69'd0) begin
            errors++;
            $display("FAIL err_clear got %h %h %0d %h %h st=%0d exp all 0",
                     num1_bcd, num2_bcd, operation, result_bcd, show_bcd, curr_state);
        end
    endtask

    task automatic test_timeout();
        int k;
        press_clr(); press_num(2); press_op(2'd2); press_num(3); press_eq();
        k = 0;
        for (int i = 1; i <= 20 && k == 0; i++) begin
            idle();
            if (curr_state === 3'd5) k = i;
        end
        checks++;
        if (k != TMO) begin
            errors++;
            $display("FAIL timeout_cycles got %0d exp %0d", k, TMO);
        end
    endtask

    task automatic test_clr_done();
        press_clr(); press_num(1); press_op(2'd0); press_num(2); press_eq(); idle();
        drive(1, 0, 0, 0, 1, 4'd0, 2'd0, 1, 0, 16'h1234);
        checks++;
        if (curr_state !== 3'd0 || result_bcd !== 16'h0 || show_bcd !== 16'h0) begin
            errors++;
            $display("FAIL clr_done got st=%0d res=%h show=%h exp 0 0 0",
                     curr_state, result_bcd, show_bcd);
        end
    endtask

    task automatic test_random();
        logic [70:0] got;
        do_reset();
        for (int i = 0; i < 800; i++) begin
            if (i == 400) begin
                do_reset();
            end else begin
                drive($urandom_range(0, 9) < 7,
                      $urandom_range(0, 9) < 7,
                      $urandom_range(0, 9) < 3,
                      $urandom_range(0, 9) < 2,
                      $urandom_range(0, 39) == 0,
                      4'($urandom_range(0, 11)),
                      2'($urandom_range(0, 3)),
                      $urandom_range(0, 5) == 0,
                      $urandom_range(0, 4) == 0,
                      to_bcd($urandom_range(0, 9999)));
            end
            got = {alu_start, num1_bcd, num2_bcd, operation, result_bcd,
                   show_bcd, disp_update, curr_state};
            checks++;
            if (got !== exp_all()) begin
                errors++;
                $display("FAIL rand_outputs cyc=%0d got %h exp %h", i, got, exp_all());
            end
        end
    endtask

    initial begin
        rst = 1;
        key_valid = 0; is_num = 0; is_op = 0; is_eq = 0; is_clr = 0;
        num_val = '0; op_val = '0;
        alu_done = 0; alu_err = 0; alu_result = '0;
        test_reset();
        test_basic();
        test_chain();
        test_digits();
        test_err();
        test_timeout();
        test_clr_done();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
